// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control path: opcodes, load-enable bit positions,
// sequencer states and the opcode legality check.
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam int         MODE_BIT = 3;

    localparam int EN_A = 0;
    localparam int EN_B = 1;
    localparam int EN_R = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    // The mode bit is forwarded to the ALU untouched, so legality ignores it.
    function automatic bit op_is_legal(logic [3:0] op);
        logic [3:0] base;
        base           = op;
        base[MODE_BIT] = 1'b0;
        case (base)
            OP_NOP, OP_ADD, OP_SUB, OP_XOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: loads A and B over the shared bus, fires the
// function, captures the result and returns it over a valid/ready response channel.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    output logic [7:0]       bus_out,
    output logic             bus_oe,
    output logic [2:0]       alu_en,
    output logic [3:0]       alu_func,
    input  logic [7:0]       alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_data,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [CNT_W-1:0] op_count
);

    state_t     state;
    logic [3:0] op_q;
    logic [7:0] b_q;

    // Every output is registered and set up on the edge that enters the state it
    // belongs to, so each state's drive appears for exactly the cycle it occupies.
    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later statements see updated state.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            // NOTE: every register, including the operand latches, is reset so a
            // dropped operation leaves nothing behind for the next request.
            state      <= ST_IDLE;
            op_q       <= '0;
            b_q        <= '0;
            req_ready  <= 1'b1;
            bus_out    <= '0;
            bus_oe     <= 1'b0;
            alu_en     <= '0;
            alu_func   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        b_q       <= req_b;
                        req_ready <= 1'b0;
                        if (op_is_legal(req_op)) begin
                            state   <= ST_LOAD_A;
                            bus_oe  <= 1'b1;
                            bus_out <= req_a;
                            alu_en  <= 3'(1 << EN_A);
                        end else begin
                            // Illegal codes never reach the ALU; answer straight away.
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_zero  <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ST_LOAD_A: begin
                    state   <= ST_LOAD_B;
                    bus_out <= b_q;
                    alu_en  <= 3'(1 << EN_B);
                end
                ST_LOAD_B: begin
                    state    <= ST_EXEC;
                    bus_oe   <= 1'b0;
                    bus_out  <= '0;
                    alu_en   <= 3'(1 << EN_R);
                    alu_func <= op_q;
                end
                ST_EXEC: begin
                    state    <= ST_CAPTURE;
                    alu_en   <= '0;
                    alu_func <= '0;
                end
                ST_CAPTURE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= alu_result;
                    resp_zero  <= (alu_result == 8'h00);
                    resp_err   <= 1'b0;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        op_count   <= op_count + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    bus_out    <= '0;
                    bus_oe     <= 1'b0;
                    alu_en     <= '0;
                    alu_func   <= '0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control-side initiator for the 8-bit ALU datapath. It accepts one operation request (opcode plus two operands) over a valid/ready handshake and sequences the ALU's shared operand bus, per-register load enables and function select across fixed cycles. It then captures the ALU result and returns it with status flags over a second valid/ready handshake. It sits between the instruction decode stage and the ALU, and is the only driver of the ALU's bus, enable and function-select inputs.

## Interface
Parameters:
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock
- async_reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  4  ALU function code
- req_a  in  8  operand A
- req_b  in  8  operand B
- bus_out  out  8  value driven onto the ALU operand bus
- bus_oe  out  1  sequencer owns the bus this cycle
- alu_en  out  3  ALU load enables: [0] A reg, [1] B reg, [2] result reg
- alu_func  out  4  ALU function select
- alu_result  in  8  ALU registered result
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_data  out  8  captured result
- resp_zero  out  1  resp_data == 0
- resp_err  out  1  illegal opcode
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- Legal opcodes: 4'b0000 NOP, 0001 ADD, 0010 SUB, 0011 XOR; the same with bit3 set (mode bit, forwarded unchanged). All other codes are illegal.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid, latch op/a/b. Legal op -> LOAD_A. Illegal op -> RESP with resp_data=0, resp_zero=1, resp_err=1; the ALU is not touched.
- LOAD_A: bus_oe=1, bus_out=a, alu_en=3'b001 -> LOAD_B.
- LOAD_B: bus_oe=1, bus_out=b, alu_en=3'b010 -> EXEC.
- EXEC: bus_oe=0, alu_func=op, alu_en=3'b100 -> CAPTURE.
- CAPTURE: register alu_result into resp_data, set resp_zero, resp_err=0 -> RESP.
- RESP: resp_valid=1. On resp_ready: op_count+1, -> IDLE. Otherwise hold all resp_* stable.
- Outside the states listed: bus_out=0, bus_oe=0, alu_en=0, alu_func=4'b0000.
- Arithmetic is performed by the ALU only: 8-bit, modulo 256, no carry or borrow out.
- req_ready is 0 in every state except IDLE. The block has no request buffering, one operation in flight.

## Timing
- Reset values: FSM=IDLE, req_ready=1, bus_out=0, bus_oe=0, alu_en=0, alu_func=0, resp_valid=0, resp_data=0, resp_zero=0, resp_err=0, op_count=0.
- Request accepted at edge E0. LOAD_A runs in cycle 1, LOAD_B in 2, EXEC in 3, CAPTURE in 4. resp_valid rises in cycle 5 (legal op). For an illegal op, resp_valid rises in cycle 1.
- Minimum request-to-request spacing: 6 cycles (legal), 2 cycles (illegal), assuming resp_ready is held high.
- resp_ready high in the same cycle resp_valid rises completes the response that cycle. req_ready rises the following cycle.
- A new request is not accepted in the RESP-exit cycle (no bypass).
- Reset asserted mid-operation: all outputs return to reset values immediately. The in-flight operation is dropped and op_count is cleared. The ALU shares async_reset, so its registers clear in the same event.

## Structure
- alu_pkg holds:
  - opcode localparams (OP_NOP, OP_ADD, OP_SUB, OP_XOR, MODE_BIT)
  - enable-bit index constants (EN_A=0, EN_B=1, EN_R=2)
  - FSM state enum
  - function op_is_legal(logic[3:0]) returning bit
- No sub-module. The block is one FSM plus the operand/response registers and the counter.

## Test plan
- ADD: a=8'h3C, b=8'h05, op=0001 -> bus shows 3C then 05 with alu_en 001 then 010; alu_en=100 in cycle 3; resp_data=8'h41, zero=0, err=0, resp_valid in cycle 5.
- SUB wrap: a=8'h05, b=8'h06, op=1010 -> alu_func=1010 in EXEC; resp_data=8'hFF.
- XOR equal: a=b=8'hA5, op=0011 -> resp_data=0, resp_zero=1; op_count increments by 1 on handshake.
- Illegal op=4'b0100 -> bus_oe and alu_en stay 0 throughout; resp_valid in cycle 1 with data=0, zero=1, err=1.
- Backpressure: resp_ready low for 3 cycles in RESP -> resp_* stable, req_ready=0, req_valid ignored; accepted on cycle 4.
- Reset asserted during LOAD_B -> outputs at reset values, op_count=0, req_ready=1 after release. The next ADD 1+1 returns 8'h02.
